// File: rtl/sliding_window_3x3_pkg.sv
// Purpose : shared constants, FSM encoding and window slot helper for the 3x3 window stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: KSIZE, WIN_PIX, state_t {S_FILL, S_STREAM}, idx(r,c) slot index.
package sliding_window_3x3_pkg;

  localparam int KSIZE   = 3;
  localparam int WIN_PIX = KSIZE * KSIZE;

  // S_FILL while rows 0..1 are arriving, S_STREAM once two full rows sit in the delays.
  typedef enum logic {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  // Slot index of window row r, column c (row-major, slot 0 is top-left).
  function automatic int idx(input int r, input int c);
    return KSIZE * r + c;
  endfunction

endpackage

// File: rtl/sliding_window_3x3_row_delay.sv
// Purpose : DEPTH-pixel delay line built as a circular register file.
// Latency : DEPTH enabled cycles from din to dout; dout is combinational from the read pointer.
// Backpressure: none; advances only when en is high, otherwise holds.
// Ports   : clk, rst (async active-low), en, din[DATA_WIDTH], dout[DATA_WIDTH].
module row_delay
  import sliding_window_3x3_pkg::*;
#(
  parameter int DEPTH      = 28,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         ptr;

  // Read-before-write: the slot about to be overwritten holds the sample
  // written exactly DEPTH enables ago.
  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[ptr] <= din;
      ptr      <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/sliding_window_3x3.sv
// Purpose : turns a raster pixel stream into 3x3 fully-inside windows for the conv MAC.
// Latency : 1 cycle from the accepted pixel completing a window to valid_out/window_out.
// Backpressure: none; every valid_in pixel is accepted, gaps simply hold all state.
// Ports   : clk, rst (async active-low), valid_in, data_in[DATA_WIDTH],
//           valid_out, window_out[9*DATA_WIDTH] (slot k at [k*DATA_WIDTH +: DATA_WIDTH]), frame_done.
module sliding_window_3x3
  import sliding_window_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          valid_out,
  output logic [WIN_PIX*DATA_WIDTH-1:0] window_out,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  state_t                state, state_nxt;
  logic                  col_last, row_last, emit;
  logic [DATA_WIDTH-1:0] d1_out, d2_out;
  logic [DATA_WIDTH-1:0] win     [WIN_PIX];
  logic [DATA_WIDTH-1:0] win_nxt [WIN_PIX];
  logic [WIN_PIX*DATA_WIDTH-1:0] win_flat;

  assign col_last = (col == CW'(IMG_WIDTH - 1));
  assign row_last = (row == RW'(IMG_HEIGHT - 1));

  // Two chained row delays: d1 is one row above the current pixel, d2 two rows above.
  row_delay #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_d1 (
    .clk(clk), .rst(rst), .en(valid_in), .din(data_in), .dout(d1_out)
  );
  row_delay #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_d2 (
    .clk(clk), .rst(rst), .en(valid_in), .din(d1_out), .dout(d2_out)
  );

  // Column counter wraps into the row counter; both wrap together at end of frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FILL;
    else      state <= state_nxt;
  end

  // Rows 0..1 of each frame never emit; this also masks stale delay data
  // left over from the previous frame.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      S_FILL: begin
        if (valid_in && row == RW'(1) && col_last) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        emit = valid_in && (col >= CW'(2));
        if (valid_in && row_last && col_last) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // Next window: shift columns left, new right column is {d2, d1, pixel} top to bottom.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < KSIZE; r++) begin
      win_nxt[idx(r, 0)] = win[idx(r, 1)];
      win_nxt[idx(r, 1)] = win[idx(r, 2)];
    end
    win_nxt[idx(0, 2)] = d2_out;
    win_nxt[idx(1, 2)] = d1_out;
    win_nxt[idx(2, 2)] = data_in;
    for (int k = 0; k < WIN_PIX; k++) win_flat[k*DATA_WIDTH +: DATA_WIDTH] = win_nxt[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WIN_PIX; k++) win[k] <= '0;
    end else if (valid_in) begin
      for (int k = 0; k < WIN_PIX; k++) win[k] <= win_nxt[k];
    end
  end

  // Output stage loads the freshly completed window so it lines up with valid_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      window_out <= '0;
    end else begin
      valid_out  <= emit;
      frame_done <= emit && row_last && col_last;
      if (emit) window_out <= win_flat;
    end
  end

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Purpose : self-checking bench for sliding_window_3x3 (5x5 and 3x4 instances side by side).
// Latency : reference model predicts outputs one cycle after each accepted pixel.
// Backpressure: none exercised beyond valid_in gaps.
module tb_sliding_window_3x3;

  localparam int WA = 5, HA = 5, WB = 3, HB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = 8'd0;

  logic        valid_out_a, frame_done_a, valid_out_b, frame_done_b;
  logic [71:0] window_out_a, window_out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sliding_window_3x3 #(.IMG_WIDTH(WA), .IMG_HEIGHT(HA), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out_a), .window_out(window_out_a), .frame_done(frame_done_a)
  );

  sliding_window_3x3 #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB), .DATA_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out_b), .window_out(window_out_b), .frame_done(frame_done_b)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each frame is stored as a flat image; window at (r,c) is rows r-2..r, cols c-2..c.
  logic [7:0]  img_a [25];
  logic [7:0]  img_b [25];
  int          pos_a, pos_b;
  logic        exp_vld_a, exp_fd_a, exp_vld_b, exp_fd_b;
  logic [71:0] exp_win_a, exp_win_b;

  function automatic logic [71:0] build(input int w, input int p, input logic [7:0] din,
                                        input logic [7:0] img [25]);
    int r, c;
    logic [71:0] v;
    r = p / w;
    c = p % w;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) v[k*8 +: 8] = din;
      else        v[k*8 +: 8] = img[(r - 2 + k / 3) * w + (c - 2 + k % 3)];
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_a <= 0; exp_vld_a <= 1'b0; exp_fd_a <= 1'b0; exp_win_a <= '0;
    end else begin
      exp_vld_a <= 1'b0;
      exp_fd_a  <= 1'b0;
      if (valid_in) begin
        img_a[pos_a] <= data_in;
        if (pos_a / WA >= 2 && pos_a % WA >= 2) begin
          exp_vld_a <= 1'b1;
          exp_win_a <= build(WA, pos_a, data_in, img_a);
          exp_fd_a  <= (pos_a == WA * HA - 1);
        end
        pos_a <= (pos_a + 1) % (WA * HA);
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_b <= 0; exp_vld_b <= 1'b0; exp_fd_b <= 1'b0; exp_win_b <= '0;
    end else begin
      exp_vld_b <= 1'b0;
      exp_fd_b  <= 1'b0;
      if (valid_in) begin
        img_b[pos_b] <= data_in;
        if (pos_b / WB >= 2 && pos_b % WB >= 2) begin
          exp_vld_b <= 1'b1;
          exp_win_b <= build(WB, pos_b, data_in, img_b);
          exp_fd_b  <= (pos_b == WB * HB - 1);
        end
        pos_b <= (pos_b + 1) % (WB * HB);
      end
    end
  end

  // ---------------- compare process ----------------
  logic        checking = 1'b0;
  logic        prev_vld_a = 1'b0;
  int          consec_a = 0;
  int          fd_cnt_a = 0;
  logic [72:0] cap_a [$];
  logic [72:0] cap_b [$];

  always @(negedge clk) begin
    if (checking) begin
      check("vld_a", 72'(valid_out_a),  72'(exp_vld_a));
      check("fd_a",  72'(frame_done_a), 72'(exp_fd_a));
      check("win_a", window_out_a,      exp_win_a);
      check("vld_b", 72'(valid_out_b),  72'(exp_vld_b));
      check("fd_b",  72'(frame_done_b), 72'(exp_fd_b));
      check("win_b", window_out_b,      exp_win_b);
      if (valid_out_a) cap_a.push_back({frame_done_a, window_out_a});
      if (valid_out_b) cap_b.push_back({frame_done_b, window_out_b});
      if (valid_out_a && prev_vld_a) consec_a++;
      if (frame_done_a) fd_cnt_a++;
      prev_vld_a = valid_out_a;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld_a", 72'(valid_out_a),  72'(0));
    check("rst_fd_a",  72'(frame_done_a), 72'(0));
    check("rst_win_a", window_out_a,      72'(0));
    check("rst_win_b", window_out_b,      72'(0));
    rst = 1'b1;
    cap_a.delete();
    cap_b.delete();
    consec_a = 0;
    fd_cnt_a = 0;
  endtask

  task automatic send(input logic [7:0] p);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = p;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  localparam logic [71:0] W_FIRST = {8'd12, 8'd11, 8'd10, 8'd7,  8'd6,  8'd5,  8'd2,  8'd1,  8'd0};
  localparam logic [71:0] W_LAST  = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};
  localparam logic [71:0] W_F2    = {8'd37, 8'd36, 8'd35, 8'd32, 8'd31, 8'd30, 8'd27, 8'd26, 8'd25};
  localparam logic [71:0] W_B0    = {8'd8,  8'd7,  8'd6,  8'd5,  8'd4,  8'd3,  8'd2,  8'd1,  8'd0};
  localparam logic [71:0] W_B1    = {8'd11, 8'd10, 8'd9,  8'd8,  8'd7,  8'd6,  8'd5,  8'd4,  8'd3};

  logic [72:0] s1 [$];
  logic [72:0] e;

  initial begin
    repeat (2) @(negedge clk);
    checking = 1'b1;

    // Scenario 1: one frame back-to-back.
    do_reset();
    for (int p = 0; p < 25; p++) send(8'(p));
    idle(3);
    check("s1_count", 72'(cap_a.size()), 72'(9));
    e = cap_a[0];
    check("s1_first", e[71:0], W_FIRST);
    check("s1_first_fd", 72'(e[72]), 72'(0));
    e = cap_a[8];
    check("s1_last", e[71:0], W_LAST);
    check("s1_last_fd", 72'(e[72]), 72'(1));
    check("s1_fd_count", 72'(fd_cnt_a), 72'(1));
    s1 = cap_a;

    // Scenario 2: valid_in on every other cycle.
    do_reset();
    for (int p = 0; p < 25; p++) begin
      send(8'(p));
      idle(1);
    end
    idle(2);
    check("s2_count", 72'(cap_a.size()), 72'(9));
    check("s2_consecutive", 72'(consec_a), 72'(0));
    for (int i = 0; i < 9; i++) check("s2_same", cap_a[i], s1[i]);

    // Scenario 3: partial frame, reset, full frame.
    do_reset();
    for (int p = 0; p < 7; p++) send(8'(p));
    idle(2);
    check("s3_pre_reset", 72'(cap_a.size()), 72'(0));
    do_reset();
    for (int p = 0; p < 25; p++) send(8'(p));
    idle(3);
    check("s3_count", 72'(cap_a.size()), 72'(9));
    for (int i = 0; i < 9; i++) check("s3_same", cap_a[i], s1[i]);

    // Scenario 4: two frames back-to-back.
    do_reset();
    for (int p = 0; p < 50; p++) send(8'(p));
    idle(3);
    check("s4_count", 72'(cap_a.size()), 72'(18));
    check("s4_fd_count", 72'(fd_cnt_a), 72'(2));
    e = cap_a[9];
    check("s4_f2_first", e[71:0], W_F2);

    // Scenario 5: 3x4 instance, pixels 0..11.
    do_reset();
    for (int p = 0; p < 12; p++) send(8'(p));
    idle(3);
    check("s5_count", 72'(cap_b.size()), 72'(2));
    e = cap_b[0];
    check("s5_w0", e[71:0], W_B0);
    check("s5_w0_fd", 72'(e[72]), 72'(0));
    e = cap_b[1];
    check("s5_w1", e[71:0], W_B1);
    check("s5_w1_fd", 72'(e[72]), 72'(1));

    // Scenario 6: all-ones pixels.
    do_reset();
    for (int p = 0; p < 25; p++) send(8'hFF);
    idle(3);
    check("s6_count", 72'(cap_a.size()), 72'(9));
    for (int i = 0; i < cap_a.size(); i++) begin
      e = cap_a[i];
      check("s6_ones", e[71:0], {72{1'b1}});
    end

    // Scenario 7: random data and random gaps over three frames, model-checked.
    do_reset();
    begin
      int sent;
      sent = 0;
      while (sent < 75) begin
        @(negedge clk);
        if ($urandom_range(0, 9) < 7) begin
          valid_in = 1'b1;
          data_in  = 8'($urandom);
          sent++;
        end else begin
          valid_in = 1'b0;
        end
      end
    end
    idle(3);
    check("s7_count", 72'(cap_a.size()), 72'(27));
    check("s7_fd_count", 72'(fd_cnt_a), 72'(3));

    // Scenario 8: random mid-frame reset then random frame.
    for (int p = 0; p < 1 + $urandom_range(0, 20); p++) send(8'($urandom));
    do_reset();
    for (int p = 0; p < 25; p++) send(8'($urandom));
    idle(3);
    check("s8_count", 72'(cap_a.size()), 72'(9));

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
